ristretto_data_mem_responder: RTL and testbench

RISTRETTO_DATA_MEM_RESPONDER -- requirements
Module: ristretto_data_mem_responder

---
 rtl/ristretto_data_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_ristretto_data_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_data_mem_responder.sv
// Single-port data memory responder with read/write request channels, a fixed
// response latency and write-priority arbitration between the two channels.
module ristretto_data_mem_responder #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MemDepth  = 1024,
  parameter int unsigned Latency   = 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   rdata_req_i,
  input  logic [AddrWidth-1:0]   rdata_addr_i,
  input  logic [DataWidth/8-1:0] rdata_strb_i,
  output logic                   rdata_ready_o,
  output logic                   rdata_valid_o,
  output logic [DataWidth-1:0]   rdata_data_o,
  input  logic                   wdata_req_i,
  input  logic [AddrWidth-1:0]   wdata_addr_i,
  input  logic [DataWidth-1:0]   wdata_data_i,
  input  logic [DataWidth/8-1:0] wdata_strb_i,
  output logic                   wdata_ready_o,
  output logic                   wdata_valid_o
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned IdxW  = $clog2(MemDepth);
  localparam int unsigned CntW  = 4;
  localparam int unsigned IdxLo = 2;
  localparam int unsigned IdxHi = IdxW + 1;
  localparam logic [CntW-1:0] CntLoad = (Latency == 0) ? '0 : CntW'(Latency - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   is_wr_q;
  logic [IdxW-1:0]        idx_q;
  logic                   in_range_q;
  logic [StrbW-1:0]       rstrb_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   rvalid_q;
  logic                   wvalid_q;

  logic                   wr_grant;
  logic                   rd_grant;
  logic [IdxW-1:0]        wr_idx;
  logic [IdxW-1:0]        rd_idx;
  logic                   wr_in_range;
  logic                   rd_in_range;
  logic [DataWidth-1:0]   rd_mask;
  logic [DataWidth-1:0]   resp_data;

  logic [DataWidth-1:0]   mem [MemDepth];

  // Write wins when both channels request in the same IDLE cycle.
  assign wr_grant = rstn_i && (state_q == IDLE) && wdata_req_i;
  assign rd_grant = rstn_i && (state_q == IDLE) && rdata_req_i && !wdata_req_i;

  assign wdata_ready_o = wr_grant;
  assign rdata_ready_o = rd_grant;
  assign rdata_valid_o = rvalid_q;
  assign wdata_valid_o = wvalid_q;
  assign rdata_data_o  = rdata_q;

  assign wr_idx      = wdata_addr_i[IdxHi:IdxLo];
  assign rd_idx      = rdata_addr_i[IdxHi:IdxLo];
  assign wr_in_range = ((wdata_addr_i >> (IdxW + 2)) == '0);
  assign rd_in_range = ((rdata_addr_i >> (IdxW + 2)) == '0);

  // Lane mask built from the captured read strobe.
  always_comb begin
    rd_mask = '0;
    for (int b = 0; b < int'(StrbW); b++) begin
      rd_mask[b*8 +: 8] = {8{rstrb_q[b]}};
    end
  end

  assign resp_data = in_range_q ? (mem[idx_q] & rd_mask) : '0;

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_grant || rd_grant) begin
          if (Latency == 0) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = CntLoad;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rstrb_q    <= '0;
      rvalid_q   <= 1'b0;
      wvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= (state_q == RESP) && !is_wr_q;
      wvalid_q <= (state_q == RESP) && is_wr_q;
      if ((state_q == RESP) && !is_wr_q) begin
        rdata_q <= resp_data;
      end
      if (wr_grant) begin
        is_wr_q    <= 1'b1;
        idx_q      <= wr_idx;
        in_range_q <= wr_in_range;
      end else if (rd_grant) begin
        is_wr_q    <= 1'b0;
        idx_q      <= rd_idx;
        in_range_q <= rd_in_range;
        rstrb_q    <= rdata_strb_i;
      end
    end
  end

  // Writes commit on the acceptance edge; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_grant && wr_in_range) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wdata_strb_i[b]) begin
          mem[wr_idx][b*8 +: 8] <= wdata_data_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ristretto_data_mem_responder.sv
// Directed bench: three responders (Latency 1, 0, 15) sharing clock and reset.
module tb_ristretto_data_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rreq   [3];
  logic [31:0] raddr  [3];
  logic [3:0]  rstrb  [3];
  logic        rready [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        wreq   [3];
  logic [31:0] waddr  [3];
  logic [31:0] wdata  [3];
  logic [3:0]  wstrb  [3];
  logic        wready [3];
  logic        wvalid [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ristretto_data_mem_responder #(
      .DataWidth(32),
      .AddrWidth(32),
      .MemDepth (1024),
      .Latency  ((g == 0) ? 1 : ((g == 1) ? 0 : 15))
    ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .rdata_req_i  (rreq[g]),
      .rdata_addr_i (raddr[g]),
      .rdata_strb_i (rstrb[g]),
      .rdata_ready_o(rready[g]),
      .rdata_valid_o(rvalid[g]),
      .rdata_data_o (rdata[g]),
      .wdata_req_i  (wreq[g]),
      .wdata_addr_i (waddr[g]),
      .wdata_data_i (wdata[g]),
      .wdata_strb_i (wstrb[g]),
      .wdata_ready_o(wready[g]),
      .wdata_valid_o(wvalid[g])
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance i; checks ready, valid timing, single pulse and read data.
  task automatic xact(input int i, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp, input string tag);
    int lat;
    lat = lat_of(i);
    @(negedge clk);
    if (wr) begin
      wreq[i] = 1'b1; waddr[i] = addr; wdata[i] = data; wstrb[i] = strb;
    end else begin
      rreq[i] = 1'b1; raddr[i] = addr; rstrb[i] = strb;
    end
    #1;
    chk({tag, "_ready"}, 32'(wr ? wready[i] : rready[i]), 32'(1));
    @(posedge clk); #1;
    chk({tag, "_busy"}, 32'(wr ? wready[i] : rready[i]), 32'(0));
    if (lat == 0) begin
      wreq[i] = 1'b0; rreq[i] = 1'b0;
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(wr ? wvalid[i] : rvalid[i]), 32'(k == lat + 1));
      if (k <= lat) chk({tag, "_busy"}, 32'(wr ? wready[i] : rready[i]), 32'(0));
      if (k == lat) begin
        wreq[i] = 1'b0; rreq[i] = 1'b0;
      end
      if (k == lat + 1 && !wr) chk({tag, "_data"}, rdata[i], exp);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(wr ? wvalid[i] : rvalid[i]), 32'(0));
    if (!wr) chk({tag, "_hold"}, rdata[i], exp);
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rreq[i] = 1'b0; raddr[i] = '0; rstrb[i] = '0;
      wreq[i] = 1'b0; waddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rvalid", 32'(rvalid[i]), 32'(0));
      chk("rst_wvalid", 32'(wvalid[i]), 32'(0));
      chk("rst_rdata", rdata[i], 32'h0);
    end
    rreq[0] = 1'b1; wreq[0] = 1'b1;
    #1;
    chk("rst_rready", 32'(rready[0]), 32'(0));
    chk("rst_wready", 32'(wready[0]), 32'(0));
    rreq[0] = 1'b0; wreq[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Basic write then read
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "wr_basic");
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "rd_basic");

    // Byte strobes
    xact(0, 1'b1, 32'h30, 32'h11223344, 4'hF, 32'h0, "wr_strb_init");
    xact(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 32'h0, "wr_strb_part");
    xact(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'h11BB33DD, "rd_strb_full");
    xact(0, 1'b0, 32'h30, 32'h0, 4'b0011, 32'h000033DD, "rd_strb_low");
    xact(0, 1'b0, 32'h32, 32'h0, 4'h0, 32'h0, "rd_strb_zero");
    xact(0, 1'b1, 32'h30, 32'h0, 4'h0, 32'h0, "wr_strb_zero");
    xact(0, 1'b0, 32'h33, 32'h0, 4'hF, 32'h11BB33DD, "rd_after_zero");

    // Simultaneous requests: write first, read at the next IDLE
    @(negedge clk);
    wreq[0] = 1'b1; waddr[0] = 32'h20; wdata[0] = 32'h5A5A5A5A; wstrb[0] = 4'hF;
    rreq[0] = 1'b1; raddr[0] = 32'h20; rstrb[0] = 4'hF;
    #1;
    chk("sim_wready", 32'(wready[0]), 32'(1));
    chk("sim_rready", 32'(rready[0]), 32'(0));
    @(posedge clk); #1;
    wreq[0] = 1'b0;
    chk("sim_rready_wait", 32'(rready[0]), 32'(0));
    @(posedge clk); #1;
    chk("sim_rready_resp", 32'(rready[0]), 32'(0));
    chk("sim_rvalid_resp", 32'(rvalid[0]), 32'(0));
    @(posedge clk); #1;
    chk("sim_wvalid", 32'(wvalid[0]), 32'(1));
    chk("sim_rready_idle", 32'(rready[0]), 32'(1));
    @(posedge clk); #1;
    rreq[0] = 1'b0;
    chk("sim_rd_wait", 32'(rvalid[0]), 32'(0));
    @(posedge clk); #1;
    chk("sim_rd_resp", 32'(rvalid[0]), 32'(0));
    @(posedge clk); #1;
    chk("sim_rd_valid", 32'(rvalid[0]), 32'(1));
    chk("sim_rd_data", rdata[0], 32'h5A5A5A5A);

    // Out-of-range accesses
    xact(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, "wr_zero_addr");
    xact(0, 1'b0, 32'h00001000, 32'h0, 4'hF, 32'h0, "rd_oor");
    xact(0, 1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, 32'h0, "wr_oor");
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h01020304, "rd_alias");

    // Latency extremes
    xact(1, 1'b1, 32'h8, 32'h12345678, 4'hF, 32'h0, "l0_wr");
    xact(1, 1'b0, 32'h8, 32'h0, 4'hF, 32'h12345678, "l0_rd");
    xact(2, 1'b1, 32'h8, 32'h87654321, 4'hF, 32'h0, "l15_wr");
    xact(2, 1'b0, 32'h8, 32'h0, 4'hF, 32'h87654321, "l15_rd");

    // Reset during a read wait
    xact(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, "wr_pre_rst");
    xact(0, 1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFEF00D, "rd_pre_rst");
    @(negedge clk);
    rreq[0] = 1'b1; raddr[0] = 32'h40; rstrb[0] = 4'hF;
    #1;
    chk("rst_rd_ready", 32'(rready[0]), 32'(1));
    @(posedge clk); #1;
    rreq[0] = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_drop_valid", 32'(rvalid[0]), 32'(0));
    chk("rst_drop_data", rdata[0], 32'h0);
    rreq[0] = 1'b1;
    #1;
    chk("rst_low_ready", 32'(rready[0]), 32'(0));
    rstn = 1'b1;
    #1;
    chk("rst_idle_ready", 32'(rready[0]), 32'(1));
    @(posedge clk); #1;
    rreq[0] = 1'b0;
    chk("rst_rd_wait", 32'(rvalid[0]), 32'(0));
    @(posedge clk); #1;
    chk("rst_rd_resp", 32'(rvalid[0]), 32'(0));
    @(posedge clk); #1;
    chk("rst_rd_valid", 32'(rvalid[0]), 32'(1));
    chk("rst_rd_data", rdata[0], 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
